// File: rtl/parity_types_pkg.sv
// Shared frame-format and receiver-state types for the parity receive path.
package parity_types_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/parity_frame_rx_bit_timer.sv
// bit_timer: reloadable down-counter that pulses expire once per loaded interval.
module bit_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expire
);

  logic [CW-1:0] cnt;
  logic          run;

  // run gates the zero detect so an idle counter parked at 0 never fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign expire = run && (cnt == '0);

endmodule

// File: rtl/parity_frame_rx.sv
// Async serial frame receiver (start, LSB-first data, optional parity, stop) with a valid/ready holding register.
// Define PARITY_FRAME_RX_SYNC_EN to pass rx through a 2-flop synchronizer before use.
module parity_frame_rx
  import parity_types_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  parity_t           parityType,
  output logic [DATA_W-1:0] dataOut,
  output logic              parityBit,
  output logic              frameErr,
  output logic              dataValid,
  input  logic              dataReady,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);

  logic              rx_s;
  rx_state_t         state;
  parity_t           frame_type;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_in;
  logic              parity_reg;
  logic [IDX_W-1:0]  bit_idx;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              expire;

`ifdef PARITY_FRAME_RX_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 2'b11;
    else        sync_reg <= {sync_reg[0], rx};
  end

  assign rx_s = sync_reg[1];
`else
  assign rx_s = rx;
`endif

  bit_timer #(.CW(CNT_W)) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  // Half-bit load on the falling edge centres every later sample mid-bit
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = FULL_LOAD;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          tmr_load = 1'b1;
          tmr_val  = HALF_LOAD;
        end
      end
      START:        tmr_load = expire && !rx_s;
      DATA, PARITY: tmr_load = expire;
      default:      tmr_load = 1'b0;
    endcase
  end

  assign shift_in = DATA_W'(rx_s) << (DATA_W - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_type <= PARITY_NONE;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      bit_idx    <= '0;
      dataOut    <= '0;
      parityBit  <= 1'b0;
      frameErr   <= 1'b0;
      dataValid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (dataValid && dataReady) dataValid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            frame_type <= parityType;
            parity_reg <= 1'b0;
            state      <= START;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (expire) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              bit_idx <= '0;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (expire) begin
            shift_reg <= (shift_reg >> 1) | shift_in;
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == LAST_IDX)
              state <= (frame_type == PARITY_NONE) ? STOP : PARITY;
          end
        end
        PARITY: begin
          if (expire) begin
            parity_reg <= rx_s;
            state      <= STOP;
          end
        end
        STOP: begin
          if (expire) begin
            state <= IDLE;
            busy  <= 1'b0;
            // A full holding register that is not being drained drops the new frame
            if (!dataValid || dataReady) begin
              dataOut   <= shift_reg;
              parityBit <= parity_reg;
              frameErr  <= ~rx_s;
              dataValid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: directed frames plus randomized traffic against a frame-level model.
`timescale 1ns/1ps
module tb_parity_frame_rx;
  import parity_types_pkg::*;

  localparam int DW = 8;
  localparam int C  = 16;
`ifdef PARITY_FRAME_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          dataReady = 1'b0;
  parity_t       parityType = PARITY_NONE;
  logic [DW-1:0] dataOut;
  logic          parityBit, frameErr, dataValid, overrun, busy;

  parity_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .parityType (parityType),
    .dataOut    (dataOut),
    .parityBit  (parityBit),
    .frameErr   (frameErr),
    .dataValid  (dataValid),
    .dataReady  (dataReady),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   edge_no;
    logic [DW-1:0] data;
    logic          pbit;
    logic          ferr;
  } frame_t;

  frame_t        sched[$];
  frame_t        cur;
  int unsigned   cyc = 0;
  int            tests = 0;
  int            fails = 0;
  int            ready_mode = 0;
  int            ov_cnt = 0;
  logic [DW-1:0] got[$];
  logic          m_valid = 1'b0, m_pbit = 1'b0, m_ferr = 1'b0, m_overrun = 1'b0;
  logic [DW-1:0] m_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: each sent frame lands in the holding register at its stop-sample edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    m_overrun = 1'b0;
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_pbit = 1'b0; m_ferr = 1'b0;
      sched.delete();
    end else if (sched.size() > 0 && sched[0].edge_no == cyc) begin
      cur = sched.pop_front();
      if (!m_valid || dataReady) begin
        m_valid = 1'b1; m_data = cur.data; m_pbit = cur.pbit; m_ferr = cur.ferr;
      end else begin
        m_overrun = 1'b1;
      end
    end else if (m_valid && dataReady) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", 32'(dataValid), 32'(m_valid));
      check("overrun", 32'(overrun), 32'(m_overrun));
      if (m_valid) begin
        check("data", 32'(dataOut), 32'(m_data));
        check("parity_bit", 32'(parityBit), 32'(m_pbit));
        check("frame_err", 32'(frameErr), 32'(m_ferr));
      end
      if (overrun) ov_cnt++;
      if (dataValid && dataReady) begin
        got.push_back(dataOut);
        $display("[TB] word 0x%02h parity %0d ferr %0d accepted at cycle %0d", dataOut, parityBit, frameErr, cyc);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       dataReady = 1'b0;
      1:       dataReady = 1'b1;
      default: dataReady = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called at 1ns after an edge; cut>0 sends only that many line bits and leaves rx as is
  task automatic send_frame(input logic [DW-1:0] d, input parity_t pt, input logic pb,
                            input logic stop, input int cut, input bit wiggle);
    logic   bits[$];
    frame_t f;
    int     nb;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pt != PARITY_NONE) bits.push_back(pb);
    bits.push_back(stop);
    nb = (cut > 0) ? cut : bits.size();
    parityType = pt;
    f.edge_no = cyc + 1 + SYNC_LAT + C / 2 + (bits.size() - 1) * C;
    f.data    = d;
    f.pbit    = (pt == PARITY_NONE) ? 1'b0 : pb;
    f.ferr    = ~stop;
    sched.push_back(f);
    for (int b = 0; b < nb; b++) begin
      rx = bits[b];
      if (b == 1 && wiggle) parityType = parity_t'($urandom_range(0, 2));
      idle(C);
    end
    if (cut == 0) rx = 1'b1;
  endtask

  task automatic drain();
    ready_mode = 1;
    idle(4);
    ready_mode = 0;
    idle(2);
    check("drain_empty", 32'(dataValid), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ov0;
    bit  seen;
    logic [DW-1:0] d;
    parity_t pt;
    logic stop;

    rst_n = 1'b0;
    idle(3);
    check("rst_data", 32'(dataOut), 32'd0);
    check("rst_pbit", 32'(parityBit), 32'd0);
    check("rst_ferr", 32'(frameErr), 32'd0);
    check("rst_valid", 32'(dataValid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Even parity 0xA5, held until accepted
    send_frame(8'hA5, PARITY_EVEN, 1'b0, 1'b1, 0, 1'b0);
    idle(4);
    check("a5_valid", 32'(dataValid), 32'd1);
    check("a5_data", 32'(dataOut), 32'hA5);
    check("a5_pbit", 32'(parityBit), 32'd0);
    check("a5_ferr", 32'(frameErr), 32'd0);
    idle(20);
    check("a5_hold", 32'(dataValid), 32'd1);
    drain();

    // Odd parity 0x07 with parity bit 0: odd overall ones count
    send_frame(8'h07, PARITY_ODD, 1'b0, 1'b1, 0, 1'b0);
    idle(4);
    check("o07_data", 32'(dataOut), 32'h07);
    check("o07_pbit", 32'(parityBit), 32'd0);
    check("o07_oddpass", 32'(^{dataOut, parityBit}), 32'd1);
    drain();

    // Back-to-back no-parity frames
    got.delete();
    ov0 = ov_cnt;
    ready_mode = 1;
    send_frame(8'h3C, PARITY_NONE, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'hC3, PARITY_NONE, 1'b1, 1'b1, 0, 1'b0);
    idle(C);
    check("b2b_count", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      check("b2b_first", 32'(got[0]), 32'h3C);
      check("b2b_second", 32'(got[1]), 32'hC3);
    end
    check("b2b_pbit", 32'(parityBit), 32'd0);
    check("b2b_no_overrun", 32'(ov_cnt - ov0), 32'd0);
    ready_mode = 0;
    idle(2);

    // 4-cycle glitch: false start
    seen = 1'b0;
    rx = 1'b0;
    for (int i = 0; i <= SYNC_LAT + C / 2; i++) begin
      @(posedge clk); #1;
      if (i == 3) rx = 1'b1;
      if (busy) seen = 1'b1;
    end
    check("glitch_busy_seen", 32'(seen), 32'd1);
    check("glitch_busy_clear", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(dataValid), 32'd0);
    idle(4);

    // Bad stop bit, then a dropped frame while the register is full
    send_frame(8'h55, PARITY_EVEN, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    check("bad_stop_data", 32'(dataOut), 32'h55);
    check("bad_stop_ferr", 32'(frameErr), 32'd1);
    idle(C);
    ov0 = ov_cnt;
    send_frame(8'h12, PARITY_NONE, 1'b0, 1'b1, 0, 1'b0);
    idle(4);
    check("overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
    check("overrun_keeps", 32'(dataOut), 32'h55);
    check("overrun_keeps_ferr", 32'(frameErr), 32'd1);
    drain();

    // Reset in the middle of data bit 3
    send_frame(8'h5A, PARITY_NONE, 1'b0, 1'b1, 4, 1'b0);
    rx = 1'b1;
    idle(C / 2);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(dataValid), 32'd0);
    check("mid_rst_data", 32'(dataOut), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(C * 2);
    check("post_rst_valid", 32'(dataValid), 32'd0);
    send_frame(8'h81, PARITY_EVEN, 1'b0, 1'b1, 0, 1'b0);
    idle(4);
    check("post_rst_data", 32'(dataOut), 32'h81);
    check("post_rst_ferr", 32'(frameErr), 32'd0);
    drain();

    // Random traffic with random back-pressure and mid-frame parityType changes
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      d    = DW'($urandom);
      pt   = parity_t'($urandom_range(0, 2));
      stop = ($urandom_range(0, 7) != 0);
      send_frame(d, pt, 1'($urandom_range(0, 1)), stop, 0, 1'b1);
      if (!stop) idle(C);
      idle($urandom_range(0, 20));
    end
    ready_mode = 1;
    idle(C * 2);
    check("final_empty", 32'(dataValid), 32'd0);
    check("final_sched", 32'(sched.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial frame receiver that sits directly upstream of `parity_check`. It recovers asynchronous serial frames (start, data LSB-first, optional parity bit, stop) from a single line. It presents the recovered data word and the received parity bit on a valid/ready interface, and `parity_check` consumes them with the same `parityType`. The receiver only delivers the raw parity bit; it does not evaluate parity.

## Interface
Parameters:
- `DATA_W`, 8, data bits per frame (1..16)
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; must be ≥4

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `rx`  in  1  serial line; idle high
- `parityType`  in  `parity_t`  frame format; `PARITY_NONE` means no parity bit is present
- `dataOut`  out  DATA_W  received data word
- `parityBit`  out  1  received parity bit; 0 when `PARITY_NONE`
- `frameErr`  out  1  stop bit was sampled low; qualified by `dataValid`
- `dataValid`  out  1  output holding register is full
- `dataReady`  in  1  downstream accepts the word
- `overrun`  out  1  one-cycle pulse when a completed frame is dropped
- `busy`  out  1  FSM is not in IDLE

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `rxS` (the conditioned `rx`) = 0 → load `bitCnt` = CLKS_PER_BIT/2 − 1, latch `parityType`, go to START.
- START:
  - When `bitCnt` hits 0, sample `rxS`.
  - Sample 1 → false start; return to IDLE with no output.
  - Sample 0 → reload `bitCnt` = CLKS_PER_BIT − 1, clear `bitIdx`, go to DATA.
- DATA:
  - Each expiry shifts `rxS` into the MSB of the shift register (LSB-first line order).
  - After DATA_W samples, go to PARITY, or go to STOP if the latched type is `PARITY_NONE`.
- PARITY: one sample into `parityReg`, then go to STOP.
- STOP:
  - One sample; `frameErr` = ~sample.
  - Deliver the frame and return to IDLE in the same cycle.
  - A frame with a bad stop bit is still delivered.
- Delivery, when `dataValid`=0 or (`dataValid` & `dataReady`) in that cycle:
  - Load `dataOut`, `parityBit` and `frameErr`; `dataValid` = 1.
- Delivery when `dataValid`=1 and `dataReady`=0:
  - The new frame is discarded and the holding register keeps the old word.
  - `overrun` = 1 for one cycle.
- `dataValid`=1 & `dataReady`=1 with no delivery → `dataValid` = 0 next cycle.
- Changes to `parityType` mid-frame have no effect until the next start bit.
- `bitCnt` width is $clog2(CLKS_PER_BIT). `bitIdx` width is $clog2(DATA_W+1). Neither counter wraps, because both reload on every state entry.

## Timing
- Reset values: `dataOut`=0, `parityBit`=0, `frameErr`=0, `dataValid`=0, `overrun`=0, `busy`=0; FSM=IDLE; all counters 0.
- Sampling points: the start bit is sampled CLKS_PER_BIT/2 cycles after the cycle in which `rxS` is first seen low. Each later bit is sampled at CLKS_PER_BIT-cycle intervals, which is mid-bit.
- Latency: `dataValid` rises the cycle after the stop-bit sample. With `rx` fed directly, that is the cycle at (CLKS_PER_BIT/2 + (1+DATA_W+P)·CLKS_PER_BIT + 1) after the start edge, where P=1 with parity and P=0 without. The synchronizer adds 2 cycles to this.
- Back-to-back frames need no idle gap: the FSM is back in IDLE half a bit before the next start edge can arrive.
- `rst_n` low mid-frame aborts the frame immediately. No partial word is delivered and no `overrun` is raised.

## Configuration
- `PARITY_FRAME_RX_SYNC_EN` defined: `rx` passes through a 2-flop synchronizer, reset to 1, to form `rxS`. Latency grows by 2 cycles.
- Macro undefined: `rxS` = `rx` directly. Use this only when the source is synchronous to `clk`.

## Structure
- `parity_t` (`PARITY_NONE`, `PARITY_EVEN`, `PARITY_ODD`) stays in `parity_types_pkg`.
- The FSM state enum `rx_state_t` is added to `parity_types_pkg`, so that `parity_check` and the benches share one definition.
- One sub-module, `bit_timer`, holds the reloadable down-counter. Its interface: load value, load strobe, expiry pulse.

## Test plan
- Even parity, 0xA5 with parity bit 0, stop 1, CLKS_PER_BIT=16 → `dataOut`=0xA5, `parityBit`=0, `frameErr`=0, `dataValid` held until `dataReady`.
- Odd parity, 0x07 with parity bit 0 → `dataOut`=0x07, `parityBit`=0. Feeding these to `parity_check` with `PARITY_ODD` gives `parityCheck` pass.
- `PARITY_NONE`, 0x3C, then a second frame 0xC3 with no gap → two deliveries in order, `parityBit`=0, `overrun` never asserted.
- `rx` low for 4 cycles only (glitch) → returns to IDLE, no `dataValid`, `busy` back to 0 within CLKS_PER_BIT/2 + 1 cycles.
- Stop bit driven 0 on frame 0x55 → delivered with `frameErr`=1. A second frame sent with `dataReady`=0 → `overrun` pulses for 1 cycle and `dataOut` stays 0x55.
- `rst_n` asserted during DATA bit 3 → all outputs at reset values. A full frame 0x81 sent after release → received correctly.
